// File: rtl/sr_sync_counter.sv
// Modulo-MODULUS up/down counter whose state is held in SR-style flops:
// S/R excitations are exposed each cycle and the register update is derived from them.
module sr_sync_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] R,
    output logic             tc,
    output logic             wrap,
    output logic             err
);

    // One extra bit so MODULUS == 2**WIDTH still compares correctly.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_q, q_d, nxt;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic             din_ok;

    always_comb begin
        din_ok = ({1'b0, din} < MOD_EXT);
        tc     = en & ~load & ((up & (q_q == Q_MAX)) | (~up & (q_q == '0)));
        nxt    = q_q;
        err_d  = err_q;
        if (load) begin
            nxt = din_ok ? din : '0;
            if (!din_ok) err_d = 1'b1;
        end else if (en) begin
            if (up) nxt = (q_q == Q_MAX) ? '0 : q_q + 1'b1;
            else    nxt = (q_q == '0) ? Q_MAX : q_q - 1'b1;
        end
        // Excitations are disjoint by construction and vanish on hold or reset.
        S      = rst ? '0 : (nxt & ~q_q);
        R      = rst ? '0 : (~nxt & q_q);
        q_d    = (q_q & ~R) | S;
        wrap_d = tc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign Q    = q_q;
    assign wrap = wrap_q;
    assign err  = err_q;

endmodule

// File: tb/tb_sr_sync_counter.sv
// Randomized + directed bench for sr_sync_counter against an arithmetic modulo-counter model.
module tb_sr_sync_counter;
    localparam int W = 4;
    localparam int M = 10;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst, en, up, load;
    logic [W-1:0] din;
    logic [W-1:0] Q, S, R;
    logic         tc, wrap, err;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    // Reference model state
    int mq = 0, merr = 0, mwrap = 0;
    logic [W-1:0] srq = '0;

    sr_sync_counter #(.WIDTH(W), .MODULUS(M)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
        .Q(Q), .S(S), .R(R), .tc(tc), .wrap(wrap), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int mnext(int q, bit ld, int d, bit e, bit u);
        if (ld) return (d < M) ? d : 0;
        if (e)  return u ? (q + 1) % M : (q + M - 1) % M;
        return q;
    endfunction

    function automatic int mtc(int q, bit ld, bit e, bit u);
        return (e && !ld && ((u && q == M - 1) || (!u && q == 0))) ? 1 : 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq <= 0; merr <= 0; mwrap <= 0;
        end else begin
            mq    <= mnext(mq, load, int'(din), en, up);
            mwrap <= mtc(mq, load, en, up);
            if (load && int'(din) >= M) merr <= 1;
        end
    end

    // Independent SR flip-flop array driven only by the DUT's S/R.
    always @(posedge clk or posedge rst) begin
        if (rst) srq <= '0;
        else for (int b = 0; b < W; b++) begin
            if (S[b])      srq[b] <= 1'b1;
            else if (R[b]) srq[b] <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            int n;
            n = rst ? mq : mnext(mq, load, int'(din), en, up);
            chk("q", int'(Q), mq);
            chk("err", int'(err), merr);
            chk("wrap", int'(wrap), mwrap);
            chk("tc", int'(tc), mtc(mq, load, en, up));
            chk("s", int'(S), (n & ~mq) & MASK);
            chk("r", int'(R), (~n & mq) & MASK);
            chk("sr_ref", int'(srq), int'(Q));
            chk("s_and_r", int'(S & R), 0);
            chk("q_range", int'(Q) < M, 1);
        end
    end

    task automatic edge1();
        @(posedge clk); #1;
    endtask

    initial begin
        int seq [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; din = '0;
        #2;
        chk("rst_q", int'(Q), 0);
        chk("rst_wrap", int'(wrap), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_s", int'(S), 0);
        chk("rst_r", int'(R), 0);
        chk_on = 1'b1;
        edge1();
        rst = 1'b0; en = 1'b1; up = 1'b1;

        // Count up 12 edges through the 9->0 wrap.
        for (int i = 0; i < 12; i++) begin
            edge1();
            chk("up_seq_q", int'(Q), seq[i]);
            chk("up_seq_wrap", int'(wrap), (i == 9) ? 1 : 0);
            chk("up_seq_tc", int'(tc), (seq[i] == 9) ? 1 : 0);
        end

        // Load 0, then one down-count: 0 -> 9 with wrap.
        load = 1'b1; din = 4'd0;
        edge1();
        load = 1'b0; up = 1'b0; en = 1'b1;
        #1;
        chk("down_s", int'(S), 4'b1001);
        chk("down_r", int'(R), 0);
        chk("down_tc", int'(tc), 1);
        edge1();
        chk("down_q", int'(Q), 9);
        chk("down_wrap", int'(wrap), 1);
        en = 1'b0;
        edge1();
        chk("down_wrap_clear", int'(wrap), 0);

        // Legal then illegal load.
        load = 1'b1; din = 4'd7; en = 1'b1; up = 1'b1;
        edge1();
        chk("load7_q", int'(Q), 7);
        chk("load7_wrap", int'(wrap), 0);
        chk("load7_err", int'(err), 0);
        din = 4'd12;
        edge1();
        chk("load12_q", int'(Q), 0);
        chk("load12_err", int'(err), 1);
        chk("load12_wrap", int'(wrap), 0);
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            edge1();
            chk("err_sticky", int'(err), 1);
        end

        // Hold at 3 for 5 edges.
        load = 1'b1; din = 4'd3;
        edge1();
        load = 1'b0; en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            edge1();
            chk("hold_q", int'(Q), 3);
            chk("hold_s", int'(S), 0);
            chk("hold_r", int'(R), 0);
            chk("hold_tc", int'(tc), 0);
        end

        // Asynchronous reset mid-cycle at Q=5 with counting enabled.
        load = 1'b1; din = 4'd5;
        edge1();
        chk("pre_rst_q", int'(Q), 5);
        load = 1'b0; en = 1'b1; up = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_q", int'(Q), 0);
        chk("async_rst_err", int'(err), 0);
        chk("async_rst_s", int'(S), 0);
        chk("async_rst_r", int'(R), 0);
        load = 1'b1; din = 4'd4;
        edge1();
        chk("rst_beats_load", int'(Q), 0);
        rst = 1'b0; load = 1'b0; en = 1'b0;
        edge1();
        chk("post_rst_idle", int'(Q), 0);

        // Random phase
        for (int i = 0; i < 1000; i++) begin
            en   = 1'($urandom_range(0, 1));
            up   = 1'($urandom_range(0, 1));
            load = ($urandom_range(0, 5) == 0);
            din  = W'($urandom_range(0, MASK));
            rst  = ($urandom_range(0, 99) == 0);
            edge1();
        end
        rst = 1'b0;
        edge1();

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
